rf_block_xfer_ctrl: RTL
=======================

# rf_block_xfer_ctrl

Sequencer that drives the 16-entry register file during multi-register block transfers (load-multiple / store-multiple). It reads a base register, walks a 16-bit register list in ascending order, and issues one memory word access per listed register. For loads it writes the returned word into the register file; for stores it routes the register through the Rm read port. It optionally writes the updated base back. It sits between the control unit and the register file / memory interface and owns the RF select and load strobes while busy.

## Interface
- `WORD_BYTES`, default 4: address stride per transfer.
- `AW`, default 32: address and data width.

- `Clk` in 1: clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `start` in 1: begin a transfer; sampled in IDLE only.
- `is_load` in 1: 1 = memory→RF, 0 = RF→memory.
- `up` in 1: 1 = increment-after, 0 = decrement-before.
- `writeback` in 1: write the updated base into the base register.
- `base` in 4: base register number.
- `reg_list` in 16: bit i set = transfer Ri.
- `rn_data` in AW: RF Rn port data (base value).
- `mem_ack` in 1: memory completes the current access this cycle.
- `rn_sel` out 4: RF Rn read select (= `base` while busy).
- `rm_sel` out 4: RF Rm read select (store data register).
- `rd_sel` out 4: RF write select.
- `rf_load` out 1: RF write enable.
- `rf_in_sel` out 1: RF input mux; 0 = memory read data, 1 = `wb_data`.
- `wb_data` out AW: updated base value.
- `mem_req` out 1: access request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out AW: word address.
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, ADDR, XFER, WB, DONE.
- IDLE, `start`=1: latch `is_load`, `up`, `writeback`, `base`, and `reg_list` into `pending`; n = popcount(`reg_list`).
  - If n = 0, go to DONE with no access and no writeback.
  - Otherwise go to ADDR.
- ADDR (1 cycle), with `rn_sel`=`base`:
  - Compute start address: `rn_data` when `up`=1; `rn_data` − WORD_BYTES·n when `up`=0.
  - Latch `wb_data`: `rn_data` + WORD_BYTES·n when `up`=1; `rn_data` − WORD_BYTES·n when `up`=0.
  - All arithmetic is modulo 2^AW.
  - Go to XFER.
- XFER:
  - cur = lowest set bit of `pending`.
  - Drive `mem_req`=1, `mem_we`=!`is_load`, `mem_addr`=current address, `rm_sel`=cur.
  - On `mem_ack`: if loading, `rf_load`=1, `rd_sel`=cur, `rf_in_sel`=0 in the same cycle.
  - On `mem_ack`: clear bit cur and add WORD_BYTES to the address.
  - When the last bit clears, go to WB if `writeback`=1 and not (`is_load`=1 and `base` in list); otherwise go to DONE.
  - Load with base in list: the loaded value wins and no writeback occurs.
  - Store with base in list: the original base value is stored.
- WB (1 cycle): `rf_load`=1, `rd_sel`=`base`, `rf_in_sel`=1. Go to DONE.
- DONE (1 cycle): `done`=1. Go to IDLE.
- `start` while busy is ignored. `mem_ack` outside XFER is ignored.
- R15 is treated as an ordinary list entry; PC handling is the control unit's job.

## Timing
- Reset (asynchronous, `RESET`=0):
  - State goes to IDLE; `pending` and address clear.
  - All outputs are 0 (selects 0, `wb_data` 0).
  - Takes effect immediately, including mid-XFER. An outstanding `mem_req` is dropped without waiting for ack.
- All outputs are Moore outputs except `rf_load` / `rd_sel` / `rf_in_sel` in XFER, which are gated combinationally by `mem_ack`.
- `mem_req`, `mem_we`, `mem_addr`, and `rm_sel` are held stable until the cycle `mem_ack`=1.
- A new request is presented the cycle after each ack; back-to-back acks give 1 transfer per cycle.
- Latency from `start` to `done` with zero-wait acks is 1 (ADDR) + n + w + 1 cycles after the start edge, where w = 1 if WB is taken.
- `busy` is high from the cycle after `start` through the DONE cycle.

## Structure
- Package `rf_ctrl_pkg`:
  - state enum (IDLE, ADDR, XFER, WB, DONE);
  - `RF_IN_MEM`=0 and `RF_IN_WB`=1 constants;
  - `WORD_BYTES` default.
- Sub-module `rf_list_scan` (combinational): takes a 16-bit list and produces the lowest-set index (4b), a `valid` flag, and popcount (5b). It is instantiated once on `pending` (cur) and once on `reg_list` (n).

## Test plan
- Reset, then `start` with `reg_list`=0 → `done` the next cycle, `mem_req` never asserted, `rf_load` never asserted.
- Load, `up`=1, `base`=R13=0x1000, list {R1,R4,R15}, writeback=1, zero-wait ack → addresses 0x1000/0x1004/0x1008, RF writes R1,R4,R15, then R13←0x100C with `rf_in_sel`=1, `done` 6 cycles after start.
- Store, `up`=0, `base`=R2=0x2000, list {R0,R2,R3}, 2-cycle ack latency → addresses 0x1FF4/0x1FF8/0x1FFC, `rm_sel` 0,2,3, `mem_we`=1, `mem_addr` stable during waits, R2←0x1FF4.
- Load with base R5 in list {R5,R6}, writeback=1 → no WB cycle, R5 holds the loaded word.
- `RESET` low during the second XFER of a 4-register load → `busy`, `mem_req`, `rf_load` low immediately; a fresh `start` after release runs a complete transfer.
- `start` pulsed during XFER and a stray `mem_ack` in IDLE → no effect on sequence, addresses, or writes.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file block-transfer sequencer.
package rf_ctrl_pkg;

  localparam int unsigned DEFAULT_WORD_BYTES = 4;

  localparam logic RF_IN_MEM = 1'b0;
  localparam logic RF_IN_WB  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StXfer,
    StWb,
    StDone
  } state_e;

endpackage

// File: rtl/rf_block_xfer_ctrl_if.sv
// Control-unit / register-file / memory signals around the block-transfer sequencer.
interface rf_block_xfer_ctrl_if #(
  parameter int unsigned AW = 32
);
  logic          start;
  logic          is_load;
  logic          up;
  logic          writeback;
  logic [3:0]    base;
  logic [15:0]   reg_list;
  logic [AW-1:0] rn_data;
  logic          mem_ack;

  logic [3:0]    rn_sel;
  logic [3:0]    rm_sel;
  logic [3:0]    rd_sel;
  logic          rf_load;
  logic          rf_in_sel;
  logic [AW-1:0] wb_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic          busy;
  logic          done;

  modport master (
    output start, is_load, up, writeback, base, reg_list, rn_data, mem_ack,
    input  rn_sel, rm_sel, rd_sel, rf_load, rf_in_sel, wb_data, mem_req, mem_we, mem_addr,
           busy, done
  );

  modport slave (
    input  start, is_load, up, writeback, base, reg_list, rn_data, mem_ack,
    output rn_sel, rm_sel, rd_sel, rf_load, rf_in_sel, wb_data, mem_req, mem_we, mem_addr,
           busy, done
  );
endinterface

// File: rtl/rf_list_scan.sv
// Combinational register-list scan: lowest set index, any-set flag and popcount.
module rf_list_scan (
  input  logic [15:0] list_i,
  output logic [3:0]  idx_o,
  output logic        valid_o,
  output logic [4:0]  count_o
);

  // Scanning downwards lets the lowest set bit be the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    count_o = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_i[i]) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
        count_o = count_o + 5'd1;
      end
    end
  end

endmodule

// File: rtl/rf_block_xfer_ctrl.sv
// Load/store-multiple sequencer: walks a register list, issues one memory access per
// register and optionally writes the updated base back.
module rf_block_xfer_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned WORD_BYTES = DEFAULT_WORD_BYTES,
  parameter int unsigned AW         = 32
) (
  input logic                 Clk,
  input logic                 RESET,
  rf_block_xfer_ctrl_if.slave bus
);

  state_e        state_q;
  logic          is_load_q, up_q, wb_en_q, base_in_list_q;
  logic [3:0]    base_q;
  logic [15:0]   pending_q;
  logic [4:0]    n_q;
  logic [AW-1:0] addr_q, wb_q;

  logic [3:0]    cur_idx, list_idx;
  logic          cur_valid, list_valid;
  logic [4:0]    cur_cnt, list_cnt;
  logic [15:0]   pending_clr;
  logic [AW-1:0] span, stride;

  rf_list_scan u_cur_scan (
    .list_i  (pending_q),
    .idx_o   (cur_idx),
    .valid_o (cur_valid),
    .count_o (cur_cnt)
  );

  rf_list_scan u_list_scan (
    .list_i  (bus.reg_list),
    .idx_o   (list_idx),
    .valid_o (list_valid),
    .count_o (list_cnt)
  );

  assign span        = AW'(WORD_BYTES) * AW'(n_q);
  assign stride      = AW'(WORD_BYTES);
  assign pending_clr = pending_q & ~(16'd1 << cur_idx);

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state_q        <= StIdle;
      is_load_q      <= 1'b0;
      up_q           <= 1'b0;
      wb_en_q        <= 1'b0;
      base_in_list_q <= 1'b0;
      base_q         <= '0;
      pending_q      <= '0;
      n_q            <= '0;
      addr_q         <= '0;
      wb_q           <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            is_load_q      <= bus.is_load;
            up_q           <= bus.up;
            wb_en_q        <= bus.writeback;
            base_q         <= bus.base;
            base_in_list_q <= bus.reg_list[bus.base];
            pending_q      <= bus.reg_list;
            n_q            <= list_cnt;
            state_q        <= list_valid ? StAddr : StDone;
          end
        end
        StAddr: begin
          addr_q  <= up_q ? bus.rn_data : bus.rn_data - span;
          wb_q    <= up_q ? bus.rn_data + span : bus.rn_data - span;
          state_q <= StXfer;
        end
        StXfer: begin
          if (bus.mem_ack && cur_valid) begin
            pending_q <= pending_clr;
            addr_q    <= addr_q + stride;
            if (pending_clr == '0) begin
              // A load that overwrites its own base keeps the loaded value.
              state_q <= (wb_en_q && !(is_load_q && base_in_list_q)) ? StWb : StDone;
            end
          end
        end
        StWb:    state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.rn_sel    = '0;
    bus.rm_sel    = '0;
    bus.rd_sel    = '0;
    bus.rf_load   = 1'b0;
    bus.rf_in_sel = RF_IN_MEM;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.wb_data   = wb_q;
    bus.busy      = (state_q != StIdle);
    bus.done      = (state_q == StDone);
    if (state_q != StIdle) begin
      bus.rn_sel = base_q;
    end
    unique case (state_q)
      StXfer: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = !is_load_q;
        bus.mem_addr = addr_q;
        bus.rm_sel   = cur_idx;
        if (bus.mem_ack && is_load_q) begin
          bus.rf_load   = 1'b1;
          bus.rd_sel    = cur_idx;
          bus.rf_in_sel = RF_IN_MEM;
        end
      end
      StWb: begin
        bus.rf_load   = 1'b1;
        bus.rd_sel    = base_q;
        bus.rf_in_sel = RF_IN_WB;
      end
      default: ;
    endcase
  end

  logic unused_scan;
  assign unused_scan = ^{cur_cnt, list_idx};

endmodule
